// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0001 << lane;
    return be;
  endfunction

  // Little-endian byte pick: lane 0 is bits [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      LANE0:   b = word[7:0];
      LANE1:   b = word[15:8];
      LANE2:   b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, asynchronous read.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: stalls the MEM stage for LATENCY cycles per
// access, then presents the registered load result for one DONE cycle.
//
//   state | meaning
//   IDLE  | no access in flight; a request stalls and arms the counter
//   WAIT  | access in flight, counter running down; request drop aborts
//   DONE  | result valid on ReadDataM, stall released; stores commit on exit
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      mem_word;
  logic [31:0]      mem_wdata;
  logic [31:0]      load_val;
  logic [3:0]       mem_be;
  logic             enter_done;
  logic             unused_addr;

  assign idx         = ALUOutM[IDX_W+1:2];
  assign lane        = ALUOutM[1:0];
  assign unused_addr = ^ALUOutM[31:IDX_W+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // WAIT ends on the edge where the decrement brings cnt to zero, so the
  // IDLE cycle plus LATENCY-1 WAIT cycles give exactly LATENCY stall cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (MemReqM) state_nxt = (LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        if (!MemReqM)                 state_nxt = IDLE;
        else if (cnt == CNT_W'(1))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    StallM    = 1'b0;
    mem_be    = BE_NONE;
    mem_wdata = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
    if (!reset) begin
      case (state)
        IDLE:    StallM = MemReqM;
        WAIT:    StallM = 1'b1;
        DONE: begin
          if (MemWriteM) mem_be = ByteM ? lane_be(lane) : BE_WORD;
        end
        default: StallM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (MemReqM) cnt <= CNT_W'(LATENCY - 1);
        WAIT:    if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign enter_done = (state_nxt == DONE) && (state != DONE);
  assign load_val   = ByteM ? {24'h0, lane_byte(mem_word, lane)} : mem_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           rdata_q <= '0;
    else if (enter_done) rdata_q <= MemWriteM ? 32'h0 : load_val;
  end

  assign ReadDataM = rdata_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .be   (mem_be),
    .addr (idx),
    .wdata(mem_wdata),
    .rdata(mem_word)
  );

endmodule
